fp_regfile: RTL and testbench

Parametrised floating-point register file with an integrated write-after-issue scoreboard, replacing the fixed 32×32 one-hot-enabled array. Writes are address-decoded, three combinational read ports feed FMA-class operations, and per-register busy bits track destinations of in-flight multi-cycle FPU operations. It sits between the FP decode/issue stage (reads, busy checks, destination reservation) and the FPU writeback bus.

---
 rtl/fp_pkg.sv | 11 +
 rtl/fp_regfile_if.sv | 46 ++++
 rtl/fp_scoreboard.sv | 63 ++++++
 rtl/fp_regfile.sv | 81 ++++++++
 tb/tb_fp_regfile.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths and types for the floating-point register file
package fp_pkg;

    localparam int FLEN  = 32;
    localparam int NREG  = 32;
    localparam int FP_AW = $clog2(NREG);

    typedef logic [FLEN-1:0]  fp_word_t;
    typedef logic [FP_AW-1:0] fp_addr_t;

endpackage

// File: rtl/fp_regfile_if.sv
// rtl/fp_regfile_if.sv - issue/read/writeback bus between FP issue, FPU writeback and register file
interface fp_regfile_if #(
    parameter int FLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [AW-1:0]   rs3_addr;
    logic [FLEN-1:0] rs1_data;
    logic [FLEN-1:0] rs2_data;
    logic [FLEN-1:0] rs3_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rs3_busy;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            issue_ready;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [FLEN-1:0] wb_data;
    logic            flush;
    logic [AW:0]     busy_count;

    modport master (
        output rs1_addr, rs2_addr, rs3_addr,
        output issue_valid, issue_rd,
        output wb_valid, wb_rd, wb_data,
        output flush,
        input  rs1_data, rs2_data, rs3_data,
        input  rs1_busy, rs2_busy, rs3_busy,
        input  issue_ready, busy_count
    );

    modport slave (
        input  rs1_addr, rs2_addr, rs3_addr,
        input  issue_valid, issue_rd,
        input  wb_valid, wb_rd, wb_data,
        input  flush,
        output rs1_data, rs2_data, rs3_data,
        output rs1_busy, rs2_busy, rs3_busy,
        output issue_ready, busy_count
    );

endinterface

// File: rtl/fp_scoreboard.sv
// rtl/fp_scoreboard.sv - per-register busy bits for in-flight FPU destinations
module fp_scoreboard
    import fp_pkg::*;
#(
    parameter int NREG     = fp_pkg::NREG,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic [AW:0]     busy_count
);

    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     count_nxt;
    logic            issue_zero;

    // Register 0 is hard-wired when ZERO_REG is set, so it never needs a reservation.
    assign issue_zero = (ZERO_REG != 0) && (issue_rd == '0);

    // A writeback to the same register frees it in time for this issue; flush squashes any issue.
    always_comb begin
        issue_ready = !flush &&
                      (issue_zero || !busy[issue_rd] || (wb_valid && (wb_rd == issue_rd)));
    end

    // Next busy vector: release on writeback, then reserve (issue wins), flush clears all.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (issue_valid && issue_ready && !issue_zero) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        count_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            count_nxt = count_nxt + {{AW{1'b0}}, busy_nxt[i]};
        end
    end

    // Busy vector and its popcount update on the same edge so they never disagree.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_nxt;
            busy_count <= count_nxt;
        end
    end

endmodule

// File: rtl/fp_regfile.sv
// rtl/fp_regfile.sv - FP register file, 3 read ports, 1 write port, busy scoreboard; option FP_REGFILE_BYPASS_EN
module fp_regfile
    import fp_pkg::*;
#(
    parameter int FLEN     = fp_pkg::FLEN,
    parameter int NREG     = fp_pkg::NREG,
    parameter int ZERO_REG = 0
) (
    input logic         clk,
    input logic         resetn,
    fp_regfile_if.slave bus
);

    localparam int AW = $clog2(NREG);

    logic [NREG-1:0] busy;
    logic [FLEN-1:0] regs [NREG];
    logic            wb_we;
    logic [AW-1:0]   rd_addr [3];
    logic [FLEN-1:0] rd_data [3];
    logic            rd_busy [3];

    assign wb_we = bus.wb_valid && !((ZERO_REG != 0) && (bus.wb_rd == '0));

    fp_scoreboard #(
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .resetn      (resetn),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .issue_ready (bus.issue_ready),
        .wb_valid    (bus.wb_valid),
        .wb_rd       (bus.wb_rd),
        .flush       (bus.flush),
        .busy        (busy),
        .busy_count  (bus.busy_count)
    );

    // Single write port; the array clears on reset and writeback data lands even during a flush.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    assign rd_addr[0] = bus.rs1_addr;
    assign rd_addr[1] = bus.rs2_addr;
    assign rd_addr[2] = bus.rs3_addr;

    // Read muxes: registered state, optionally overridden by the writeback in flight this cycle.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_data[p] = regs[rd_addr[p]];
            rd_busy[p] = busy[rd_addr[p]];
`ifdef FP_REGFILE_BYPASS_EN
            if (wb_we && (bus.wb_rd == rd_addr[p])) begin
                rd_data[p] = bus.wb_data;
                rd_busy[p] = 1'b0;
            end
`endif
            if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign bus.rs1_data = rd_data[0];
    assign bus.rs2_data = rd_data[1];
    assign bus.rs3_data = rd_data[2];
    assign bus.rs1_busy = rd_busy[0];
    assign bus.rs2_busy = rd_busy[1];
    assign bus.rs3_busy = rd_busy[2];

endmodule

// File: tb/tb_fp_regfile.sv
// tb/tb_fp_regfile.sv - scoreboard bench for fp_regfile (ZERO_REG=1), both FP_REGFILE_BYPASS_EN builds
module tb_fp_regfile;
    import fp_pkg::*;

`ifdef FP_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int RS1D = 0;
    localparam int RS1B = 1;
    localparam int RS2D = 2;
    localparam int RS2B = 3;
    localparam int RS3D = 4;
    localparam int RS3B = 5;
    localparam int CNT  = 6;
    localparam int RDY  = 7;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    fp_regfile_if #(.FLEN(FLEN), .NREG(NREG)) bus ();

    fp_regfile #(
        .FLEN     (FLEN),
        .NREG     (NREG),
        .ZERO_REG (1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    function automatic logic [31:0] act_of(int sel);
        case (sel)
            RS1D:    return bus.rs1_data;
            RS1B:    return {31'b0, bus.rs1_busy};
            RS2D:    return bus.rs2_data;
            RS2B:    return {31'b0, bus.rs2_busy};
            RS3D:    return bus.rs3_data;
            RS3B:    return {31'b0, bus.rs3_busy};
            CNT:     return {26'b0, bus.busy_count};
            default: return {31'b0, bus.issue_ready};
        endcase
    endfunction

    // Monitor: pops every expectation due this cycle and compares it against the live outputs.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_chk++;
            if (e.cyc < cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else begin
                act = act_of(e.sel);
                if (act !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic want(int sel, logic [31:0] v, string n);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.val  = v;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.flush       = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn       = 1'b0;
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        bus.rs3_addr = '0;
        bus.flush    = 1'b0;
        // Junk issue/writeback during reset must be ignored.
        bus.wb_valid    = 1'b1;
        bus.wb_rd       = fp_addr_t'(3);
        bus.wb_data     = 32'hDEADBEEF;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = fp_addr_t'(6);
        tick();
        resetn = 1'b1;
        idle();

        // Reset state over every register.
        for (int r = 0; r < NREG; r++) begin
            bus.rs1_addr = fp_addr_t'(r);
            bus.rs2_addr = fp_addr_t'(r + 1);
            bus.rs3_addr = fp_addr_t'(r + 2);
            want(RS1D, 32'h0, "reset_rs1_data");
            want(RS1B, 32'h0, "reset_rs1_busy");
            want(RS2D, 32'h0, "reset_rs2_data");
            want(RS2B, 32'h0, "reset_rs2_busy");
            want(RS3D, 32'h0, "reset_rs3_data");
            want(RS3B, 32'h0, "reset_rs3_busy");
            want(CNT,  32'h0, "reset_count");
            tick();
        end

        // Issue rd=5, WAW stall, then writeback.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = fp_addr_t'(5);
        bus.rs1_addr    = fp_addr_t'(5);
        want(RDY,  32'h1, "issue5_ready");
        want(CNT,  32'h0, "issue5_count_before");
        want(RS1B, 32'h0, "issue5_busy_before");
        tick();
        want(RDY,  32'h0, "issue5_waw_stall");
        want(RS1B, 32'h1, "issue5_busy_set");
        want(CNT,  32'h1, "issue5_count1");
        tick();
        bus.issue_valid = 1'b0;
        bus.wb_valid    = 1'b1;
        bus.wb_rd       = fp_addr_t'(5);
        bus.wb_data     = 32'h3F800000;
        want(CNT,  32'h1, "stall_count_stays1");
        want(RS1D, BYP ? 32'h3F800000 : 32'h0, "wb5_same_cycle_data");
        want(RS1B, BYP ? 32'h0 : 32'h1, "wb5_same_cycle_busy");
        tick();
        idle();
        want(RS1D, 32'h3F800000, "wb5_data");
        want(RS1B, 32'h0, "wb5_busy_clear");
        want(CNT,  32'h0, "wb5_count0");
        tick();

        // Same-cycle issue and writeback to rd=7.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = fp_addr_t'(7);
        bus.wb_valid    = 1'b1;
        bus.wb_rd       = fp_addr_t'(7);
        bus.wb_data     = 32'h40000000;
        bus.rs2_addr    = fp_addr_t'(7);
        want(RDY, 32'h1, "issue7_ready");
        tick();
        idle();
        want(RS2D, 32'h40000000, "issue_wb7_data");
        want(RS2B, 32'h1, "issue_wb7_busy_wins");
        want(CNT,  32'h1, "issue_wb7_count");
        tick();
        // rd=7 busy, but a writeback to it this cycle lets the new issue through.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = fp_addr_t'(7);
        bus.wb_valid    = 1'b1;
        bus.wb_rd       = fp_addr_t'(7);
        bus.wb_data     = 32'h40400000;
        want(RDY,  32'h1, "issue7_wb_release_ready");
        want(RS2D, BYP ? 32'h40400000 : 32'h40000000, "reissue7_same_cycle_data");
        want(RS2B, BYP ? 32'h0 : 32'h1, "reissue7_same_cycle_busy");
        tick();
        idle();
        want(RS2D, 32'h40400000, "reissue7_data");
        want(RS2B, 32'h1, "reissue7_busy");
        want(CNT,  32'h1, "reissue7_count");
        tick();
        bus.wb_valid = 1'b1;
        bus.wb_rd    = fp_addr_t'(7);
        bus.wb_data  = 32'h40400000;
        tick();
        idle();
        want(RS2B, 32'h0, "wb7_busy_clear");
        want(CNT,  32'h0, "wb7_count0");
        tick();

        // Three reservations, then flush with a writeback and a dropped issue.
        for (int r = 1; r <= 3; r++) begin
            bus.issue_valid = 1'b1;
            bus.issue_rd    = fp_addr_t'(r);
            tick();
        end
        idle();
        bus.flush       = 1'b1;
        bus.wb_valid    = 1'b1;
        bus.wb_rd       = fp_addr_t'(4);
        bus.wb_data     = 32'hC0490FDB;
        bus.issue_valid = 1'b1;
        bus.issue_rd    = fp_addr_t'(8);
        bus.rs1_addr    = fp_addr_t'(1);
        bus.rs2_addr    = fp_addr_t'(2);
        bus.rs3_addr    = fp_addr_t'(3);
        want(CNT,  32'h3, "pre_flush_count3");
        want(RS1B, 32'h1, "pre_flush_busy1");
        want(RS2B, 32'h1, "pre_flush_busy2");
        want(RS3B, 32'h1, "pre_flush_busy3");
        want(RDY,  32'h0, "flush_blocks_issue");
        tick();
        idle();
        bus.rs1_addr = fp_addr_t'(4);
        bus.rs2_addr = fp_addr_t'(2);
        bus.rs3_addr = fp_addr_t'(8);
        want(CNT,  32'h0, "flush_count0");
        want(RS1D, 32'hC0490FDB, "flush_wb4_data");
        want(RS1B, 32'h0, "flush_busy4");
        want(RS2B, 32'h0, "flush_busy2");
        want(RS3B, 32'h0, "flush_issue8_dropped");
        tick();

        // Hard-wired register 0.
        bus.wb_valid = 1'b1;
        bus.wb_rd    = '0;
        bus.wb_data  = 32'hFFFFFFFF;
        bus.rs1_addr = '0;
        want(RS1D, 32'h0, "zero_wb_no_bypass");
        want(RS1B, 32'h0, "zero_wb_busy");
        tick();
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = '0;
        want(RS1D, 32'h0, "zero_read_data");
        want(RS1B, 32'h0, "zero_read_busy");
        want(RDY,  32'h1, "zero_issue_ready");
        want(CNT,  32'h0, "zero_wb_count");
        tick();
        idle();
        want(RS1B, 32'h0, "zero_issue_not_busy");
        want(CNT,  32'h0, "zero_issue_count");
        tick();

        // Writeback bypass window on rd=9.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = fp_addr_t'(9);
        tick();
        idle();
        bus.rs2_addr = fp_addr_t'(9);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = fp_addr_t'(9);
        bus.wb_data  = 32'h12345678;
        want(RS2D, BYP ? 32'h12345678 : 32'h0, "bypass9_data");
        want(RS2B, BYP ? 32'h0 : 32'h1, "bypass9_busy");
        want(CNT,  32'h1, "bypass9_count");
        tick();
        idle();
        want(RS2D, 32'h12345678, "wb9_data");
        want(RS2B, 32'h0, "wb9_busy");
        want(CNT,  32'h0, "wb9_count");
        tick();

        // Reserve every non-zero register: count reaches NREG-1.
        for (int r = 1; r < NREG; r++) begin
            bus.issue_valid = 1'b1;
            bus.issue_rd    = fp_addr_t'(r);
            want(RDY, 32'h1, "fill_ready");
            tick();
        end
        idle();
        bus.issue_rd = fp_addr_t'(NREG - 1);
        bus.rs1_addr = fp_addr_t'(NREG - 1);
        want(CNT,  32'(NREG - 1), "fill_count_max");
        want(RS1B, 32'h1, "fill_busy_last");
        want(RDY,  32'h0, "fill_ready_busy");
        tick();

        // Reset mid-operation drops reservations and clears data.
        resetn          = 1'b0;
        bus.wb_valid    = 1'b1;
        bus.wb_rd       = fp_addr_t'(13);
        bus.wb_data     = 32'hA5A5A5A5;
        tick();
        resetn = 1'b1;
        idle();
        bus.rs1_addr = fp_addr_t'(5);
        bus.rs2_addr = fp_addr_t'(NREG - 1);
        bus.rs3_addr = fp_addr_t'(13);
        want(RS1D, 32'h0, "midreset_data5");
        want(RS2B, 32'h0, "midreset_busy_last");
        want(RS3D, 32'h0, "midreset_wb_ignored");
        want(CNT,  32'h0, "midreset_count");
        tick();
        // Writeback to a non-busy register after reset.
        bus.wb_valid = 1'b1;
        bus.wb_rd    = fp_addr_t'(11);
        bus.wb_data  = 32'h55AA55AA;
        bus.rs1_addr = fp_addr_t'(11);
        want(CNT, 32'h0, "postreset_wb_count");
        tick();
        idle();
        want(RS1D, 32'h55AA55AA, "postreset_wb_data");
        want(RS1B, 32'h0, "postreset_wb_busy");
        want(CNT,  32'h0, "postreset_wb_count_after");
        tick();
        tick();

        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
